// File: rtl/lcd_ctrl.sv
// LCD command/data streamer: Wishbone register file feeding a command FIFO that
// a small drain FSM pushes to the LCD PHY, with repeat counts and frame-mark pacing.
module lcd_ctrl #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int RPT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   wb_wdata,
  output logic [31:0]   wb_rdata,
  input  logic [1:0]    wb_addr,
  input  logic          wb_we,
  input  logic          wb_cyc,
  output logic          wb_ack,
  output logic [DW-1:0] phy_data,
  output logic          phy_rs,
  output logic          phy_valid,
  input  logic          phy_ready,
  input  logic          phy_ena,
  input  logic          phy_fmark_stb,
  output logic          phy_rst,
  output logic          phy_cs
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic             rs;
    logic [RPT_W-1:0] rpt;
    logic [DW-1:0]    data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WAIT_FM, SEND} state_t;

  state_t state, nxt;

  logic          csr_rst, csr_cs, fm_wait, fm_pend, ovf;
  logic          wr, wr_csr, flush, push_req, push, pop, fm_clr;
  logic          empty, full, eligible, xfer, last;
  logic [AW:0]   wr_ptr, rd_ptr, level;
  logic [31:0]   csr_rd;
  logic [RPT_W-1:0] cnt;
  entry_t        push_ent, head;
  entry_t        mem [FIFO_DEPTH];
  logic          unused_ok;

  assign unused_ok = ^wb_wdata;

  // Side effects happen only in the ack cycle; the bus holds its inputs until then.
  assign wr       = wb_ack & wb_cyc & wb_we;
  assign wr_csr   = wr & (wb_addr == 2'd0);
  assign flush    = wr_csr & wb_wdata[3];
  assign push_req = wr & (wb_addr != 2'd0);

  always_comb begin
    push_ent      = '0;
    push_ent.rs   = (wb_addr != 2'd1);
    push_ent.data = wb_wdata[DW-1:0];
    if (wb_addr == 2'd3) push_ent.rpt = wb_wdata[16 +: RPT_W];
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
  // A full FIFO still accepts a push in the same cycle it pops.
  assign push  = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign csr_rd = {{(15-AW){1'b0}}, level, 7'b0, ovf, phy_ena, full, empty,
                   fm_pend, 1'b0, fm_wait, csr_cs, csr_rst};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
    end else begin
      wb_ack   <= wb_cyc & ~wb_ack;
      wb_rdata <= (wb_cyc && !wb_ack && wb_addr == 2'd0) ? csr_rd : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rst <= 1'b0;
      csr_cs  <= 1'b0;
      fm_wait <= 1'b0;
      fm_pend <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (wr_csr) begin
        csr_rst <= wb_wdata[0];
        csr_cs  <= wb_wdata[1];
      end
      if (fm_clr) fm_wait <= 1'b0;
      if (wr_csr && wb_wdata[2]) fm_wait <= 1'b1;
      // Hardware set beats a software clear in the same cycle.
      fm_pend <= (fm_pend & ~(wr_csr & wb_wdata[4])) | phy_fmark_stb;
      ovf     <= (ovf & ~(wr_csr & wb_wdata[8])) | (push_req & full & ~pop);
    end
  end

  assign phy_rst = csr_rst;
  assign phy_cs  = csr_cs;

  assign eligible  = ~fm_wait & ~empty & phy_ena;
  assign phy_valid = (state == SEND);
  assign xfer      = phy_valid & phy_ready;
  assign last      = xfer & (cnt == '0);

  always_comb begin
    nxt    = state;
    pop    = 1'b0;
    fm_clr = 1'b0;
    case (state)
      IDLE: begin
        if (fm_wait) nxt = WAIT_FM;
        else if (eligible) begin
          pop = 1'b1;
          nxt = SEND;
        end
      end
      WAIT_FM: begin
        if (phy_fmark_stb) begin
          fm_clr = 1'b1;
          nxt    = IDLE;
        end
      end
      SEND: begin
        if (last) begin
          if (eligible) pop = 1'b1;
          else          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
    if (flush) begin
      pop = 1'b0;
      nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phy_data <= '0;
      phy_rs   <= 1'b0;
      cnt      <= '0;
    end else if (flush) begin
      phy_data <= '0;
      phy_rs   <= 1'b0;
      cnt      <= '0;
    end else if (pop) begin
      phy_data <= head.data;
      phy_rs   <= head.rs;
      cnt      <= head.rpt;
    end else if (xfer && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: writes queue the expected PHY beats, a monitor
// pops and compares every accepted beat.
module tb_lcd_ctrl;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 0, rst_n = 0;
  logic [31:0]   wb_wdata = 0, wb_rdata;
  logic [1:0]    wb_addr = 0;
  logic          wb_we = 0, wb_cyc = 0, wb_ack;
  logic [DW-1:0] phy_data;
  logic          phy_rs, phy_valid, phy_ready, phy_ena = 1, phy_fmark_stb = 0;
  logic          phy_rst, phy_cs;
  logic          rdy_fixed = 1, rand_rdy = 0, rdy_rnd = 1;

  int n_chk = 0, n_fail = 0, beats = 0;
  logic [DW:0] exp_q[$];

  assign phy_ready = rand_rdy ? rdy_rnd : rdy_fixed;

  lcd_ctrl #(.DW(DW), .FIFO_DEPTH(DEPTH), .RPT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
    .wb_addr(wb_addr), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
    .phy_data(phy_data), .phy_rs(phy_rs), .phy_valid(phy_valid),
    .phy_ready(phy_ready), .phy_ena(phy_ena), .phy_fmark_stb(phy_fmark_stb),
    .phy_rst(phy_rst), .phy_cs(phy_cs));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rdy_rnd = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && phy_valid && phy_ready) begin
      beats++;
      if (exp_q.size() == 0) chk("unexpected_beat", {23'b0, phy_rs, phy_data}, 32'hFFFF_FFFF);
      else chk("beat", {23'b0, phy_rs, phy_data}, {23'b0, exp_q.pop_front()});
    end
  end

  // Reference: addr1 -> command word, addr2 -> data word, addr3 -> rpt+1 data words.
  function automatic void model_push(input logic [1:0] a, input logic [31:0] d);
    int n;
    n = (a == 2'd3) ? int'(d[31:16]) + 1 : 1;
    for (int i = 0; i < n; i++) exp_q.push_back({(a != 2'd1), d[DW-1:0]});
  endfunction

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input bit accept);
    @(posedge clk); #1;
    wb_cyc = 1; wb_we = 1; wb_addr = a; wb_wdata = d;
    @(posedge clk); #1;
    chk("wr_ack", {31'b0, wb_ack}, 32'd1);
    @(posedge clk);
    if (a != 2'd0 && accept) model_push(a, d);
    #1 wb_cyc = 0; wb_we = 0;
  endtask

  task automatic wb_read(input string name, input logic [31:0] exp);
    @(posedge clk); #1;
    wb_cyc = 1; wb_we = 0; wb_addr = 2'd0;
    @(posedge clk); #1;
    chk({name, "_ack"}, {31'b0, wb_ack}, 32'd1);
    chk(name, wb_rdata, exp);
    @(posedge clk); #1;
    chk({name, "_idle"}, {31'b0, wb_ack} | wb_rdata, 32'd0);
    wb_cyc = 0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || phy_valid) && k < 1000) begin
      @(posedge clk); k++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (5) @(posedge clk);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    chk("rst_outs", {26'b0, phy_valid, phy_rs, phy_rst, phy_cs, wb_ack, |phy_data}, 0);
    #2 rst_n = 1;
    chk("rst_rdata", wb_rdata, 0);
    wb_read("csr_reset", 32'h0000_00A0);

    // single command beat, two-cycle latency
    wb_write(2'd1, 32'h0000_002A, 1);
    chk("lat_t1", {31'b0, phy_valid}, 0);
    @(posedge clk); #1;
    chk("lat_t2", {23'b0, phy_valid, phy_rs, phy_data}, {23'b0, 1'b1, 1'b0, 8'h2A});
    wait_drain("single");

    // repeated entry with a ready gap
    beats = 0;
    wb_write(2'd3, 32'h0003_00F8, 1);
    @(posedge clk); #1 rdy_fixed = 0;
    repeat (3) @(posedge clk);
    #1 rdy_fixed = 1;
    wait_drain("rpt");
    chk("rpt_beats", beats, 4);

    wb_write(2'd0, 32'h3, 1);
    #1 chk("pins", {30'b0, phy_rst, phy_cs}, 32'h3);
    wb_read("csr_pins", 32'h0000_00A3);
    wb_write(2'd0, 32'h0, 1);

    // overflow with PHY disabled
    phy_ena = 0;
    for (int i = 0; i <= DEPTH; i++) wb_write(2'd2, 32'h40 + i, i < DEPTH);
    wb_read("csr_full", 32'h0010_0140);
    phy_ena = 1;
    wait_drain("ovf");
    wb_write(2'd0, 32'h100, 1);
    wb_read("csr_ovf_clr", 32'h0000_00A0);

    // frame-mark pacing
    wb_write(2'd0, 32'h4, 1);
    wb_write(2'd2, 32'h11, 1);
    wb_write(2'd2, 32'h22, 1);
    seen = 0;
    repeat (10) begin @(negedge clk); seen |= phy_valid; end
    chk("fm_hold", {31'b0, seen}, 0);
    @(posedge clk); #1 phy_fmark_stb = 1;
    @(posedge clk); #1 phy_fmark_stb = 0;
    wait_drain("fm");
    wb_read("csr_fm", 32'h0000_00B0);
    wb_write(2'd0, 32'h10, 1);
    wb_read("csr_fm_clr", 32'h0000_00A0);

    // randomized traffic; fewer than DEPTH entries so nothing drops
    rand_rdy = 1;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] a;
      logic [31:0] d;
      a = 2'($urandom_range(1, 3));
      d = $urandom;
      if (a == 2'd3) d[31:16] = 16'($urandom_range(0, 3));
      wb_write(a, d, 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain("rand");
    rand_rdy = 0;

    // flush mid-burst
    wb_write(2'd3, 32'h0014_0055, 1);
    wb_write(2'd2, 32'h66, 1);
    wb_write(2'd0, 32'h8, 1);
    exp_q.delete();
    chk("flush_valid", {31'b0, phy_valid}, 0);
    wb_read("csr_flush", 32'h0000_00A0);
    wait_drain("flush");

    // reset mid-burst
    wb_write(2'd0, 32'h3, 1);
    wb_write(2'd3, 32'h001E_0077, 1);
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    #1 chk("mid_rst", {25'b0, phy_valid, phy_rs, phy_rst, phy_cs, wb_ack, |phy_data, |wb_rdata}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= phy_valid; end
    chk("post_rst_quiet", {31'b0, seen}, 0);
    wb_read("csr_post_rst", 32'h0000_00A0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
